// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/sub sequencer with a bit-serial align/normalise datapath.
// Denormals flush to zero, rounding is toward zero, and the result is registered behind a valid/ready handshake.
module fp_addsub_seq #(
  parameter int unsigned BYPASS_THRESH = 24,
  parameter int unsigned MANT_W        = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        bypass
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = MANT_W - 1;
  localparam int unsigned CNT_W  = 5;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic                op_sub_q, op_sub_d;
  logic                sx_q, sx_d, sy_q, sy_d;
  logic [EXP_W-1:0]    ex_q, ex_d;
  logic [MANT_W-1:0]   mx_q, mx_d, my_q, my_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         result_q, result_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                bypass_q, bypass_d;
  logic                out_valid_q, out_valid_d;

  // Unpacked operand fields; zero exponent clears the mantissa (denormal flush)
  logic              sa, sb, a_nan, b_nan, a_ge_b;
  logic [EXP_W-1:0]  ea, eb, ux_e, uy_e, d;
  logic [MANT_W-1:0] ma, mb, ux_m, uy_m;
  logic              ux_s, uy_s;
  logic [MANT_W:0]   sum;
  logic [MANT_W-1:0] diff;
  logic [EXP_W-1:0]  ex_inc, ex_dec;

  always_comb begin
    sa     = a_q[31];
    sb     = b_q[31] ^ op_sub_q;
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    ma     = (ea == '0) ? '0 : {1'b1, a_q[FRAC_W-1:0]};
    mb     = (eb == '0) ? '0 : {1'b1, b_q[FRAC_W-1:0]};
    a_nan  = (ea == EXP_MAX) && (a_q[FRAC_W-1:0] != '0);
    b_nan  = (eb == EXP_MAX) && (b_q[FRAC_W-1:0] != '0);
    a_ge_b = (ea > eb) || ((ea == eb) && (ma >= mb));
    ux_s   = a_ge_b ? sa : sb;
    ux_e   = a_ge_b ? ea : eb;
    ux_m   = a_ge_b ? ma : mb;
    uy_s   = a_ge_b ? sb : sa;
    uy_e   = a_ge_b ? eb : ea;
    uy_m   = a_ge_b ? mb : ma;
    d      = ux_e - uy_e;
    sum    = {1'b0, mx_q} + {1'b0, my_q};
    diff   = mx_q - my_q;
    ex_inc = ex_q + EXP_W'(1);
    ex_dec = ex_q - EXP_W'(1);
  end

  assign in_ready = (state_q == S_IDLE);

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_sub_d    = op_sub_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    ex_d        = ex_q;
    mx_d        = mx_q;
    my_d        = my_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    bypass_d    = bypass_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d         = a;
          b_d         = b;
          op_sub_d    = op_sub;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          bypass_d    = 1'b0;
          state_d     = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if ((ea == EXP_MAX) || (eb == EXP_MAX)) begin
          bypass_d   = 1'b1;
          overflow_d = 1'b1;
          if (a_nan || b_nan || ((ea == EXP_MAX) && (eb == EXP_MAX) && (sa != sb)))
            result_d = QNAN;
          else
            result_d = {ux_s, EXP_MAX, FRAC_W'(0)};
          state_d = S_DONE;
        end else if ((uy_e == '0) || (32'(d) > BYPASS_THRESH)) begin
          bypass_d = 1'b1;
          result_d = {ux_s, ux_e, ux_m[FRAC_W-1:0]};
          state_d  = S_DONE;
        end else begin
          sx_d    = ux_s;
          sy_d    = uy_s;
          ex_d    = ux_e;
          mx_d    = ux_m;
          my_d    = uy_m;
          cnt_d   = d[CNT_W-1:0];
          state_d = (d == '0) ? S_ADD : S_ALIGN;
        end
      end
      S_ALIGN: begin
        my_d  = my_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_ADD;
      end
      S_ADD: begin
        state_d = S_DONE;
        if (sx_q == sy_q) begin
          if (sum[MANT_W]) begin
            if (ex_inc == EXP_MAX) begin
              overflow_d = 1'b1;
              result_d   = {sx_q, EXP_MAX, FRAC_W'(0)};
            end else begin
              result_d = {sx_q, ex_inc, sum[FRAC_W:1]};
            end
          end else begin
            result_d = {sx_q, ex_q, sum[FRAC_W-1:0]};
          end
        end else if (diff == '0) begin
          result_d = '0;
        end else if (diff[MANT_W-1]) begin
          result_d = {sx_q, ex_q, diff[FRAC_W-1:0]};
        end else begin
          mx_d    = diff;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (ex_q == EXP_W'(1)) begin
          underflow_d = 1'b1;
          result_d    = {sx_q, 31'(0)};
          state_d     = S_DONE;
        end else begin
          mx_d = mx_q << 1;
          ex_d = ex_dec;
          if (mx_q[MANT_W-2]) begin
            result_d = {sx_q, ex_dec, mx_q[FRAC_W-2:0], 1'b0};
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_sub_q    <= 1'b0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      ex_q        <= '0;
      mx_q        <= '0;
      my_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      bypass_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_sub_q    <= op_sub_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      ex_q        <= ex_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      bypass_q    <= bypass_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign bypass    = bypass_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed self-checking bench for fp_addsub_seq: results, flags, latency, backpressure and reset.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        bypass;

  int n_checks = 0;
  int n_fail   = 0;

  fp_addsub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .bypass    (bypass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic start_txn(input logic [31:0] av, input logic [31:0] bv, input logic op);
    @(negedge clk);
    a_i      = av;
    b_i      = bv;
    op_sub   = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counted in cycles from the accept cycle to the first out_valid cycle
  task automatic wait_result(output int lat);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 200);
    lat = n + 1;
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_r,
                              input logic [2:0] exp_flags, input int exp_lat, input int lat);
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/result"}, result, exp_r);
    chk({tag, "/flags_ov_un_bp"}, {29'b0, overflow, underflow, bypass}, {29'b0, exp_flags});
  endtask

  task automatic handoff(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "/handoff_vld_rdy"}, {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  task automatic run_txn(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic op, input logic [31:0] exp_r,
                         input logic [2:0] exp_flags, input int exp_lat);
    int lat;
    start_txn(av, bv, op);
    wait_result(lat);
    check_result(tag, exp_r, exp_flags, exp_lat, lat);
    handoff(tag);
  endtask

  initial begin
    int   lat;
    int   bad;
    logic [31:0] held;

    #12;
    chk("reset_outputs", {result[31:4], out_valid, overflow, underflow, bypass},
        32'h0000_0000);
    chk("reset_result_lo", {28'b0, result[3:0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

    // flags order: {overflow, underflow, bypass}
    run_txn("one_plus_one",   32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000, 3);
    run_txn("too_large_byp",  32'h3F80_0000, 32'h4C00_0000, 1'b1, 32'hCC00_0000, 3'b001, 2);
    run_txn("d24_boundary",   32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b000, 27);
    run_txn("cancel",         32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b000, 3);
    run_txn("one_plus_half",  32'h3F80_0000, 32'h3F00_0000, 1'b0, 32'h3FC0_0000, 3'b000, 4);
    run_txn("neg_swap_norm",  32'h3F80_0000, 32'hC000_0000, 1'b0, 32'hBF80_0000, 3'b000, 5);
    run_txn("overflow_inf",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b100, 3);
    run_txn("inf_minus_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 3'b101, 2);
    run_txn("inf_plus_one",   32'h3F80_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000, 3'b101, 2);
    run_txn("zero_operand",   32'h4040_0000, 32'h0000_0000, 1'b1, 32'h4040_0000, 3'b001, 2);
    run_txn("underflow",      32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 3'b010, 4);

    // Partial cancel, then hold the result under backpressure with a competing request
    start_txn(32'h3FC0_0000, 32'h3F80_0000, 1'b1);
    wait_result(lat);
    check_result("partial_cancel", 32'h3F00_0000, 3'b000, 4, lat);
    held = result;
    @(negedge clk);
    a_i      = 32'h3F80_0000;
    b_i      = 32'h3F80_0000;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    chk("backpressure_hold_errs", 32'(bad), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handoff_vld_rdy", {30'b0, out_valid, in_ready}, 32'b01);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", {31'b0, in_ready}, 32'd0);
    wait_result(lat);
    check_result("bp_next_pair", 32'h4000_0000, 3'b000, 3, lat);
    handoff("bp_next_pair");

    // Reset during ALIGN discards the transaction
    start_txn(32'h3F80_0000, 32'h3E80_0000, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_result", result, 32'h0);
    chk("midreset_flags_vld", {28'b0, out_valid, overflow, underflow, bypass}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    chk("midreset_no_stale", 32'(bad), 32'd0);

    run_txn("after_reset", 32'h3F80_0000, 32'h3E80_0000, 1'b0, 32'h3FA0_0000, 3'b000, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
